// File: rtl/morse_input_sequencer_if.sv
// Handshake bundle between the Morse decoder front end and its user:
// key/backspace/enable in, letter-in-progress and character buffer out.
`timescale 1ns/1ps
interface morse_input_sequencer_if;
  logic        i_enable;
  logic        i_keyIn;
  logic        i_bkspPulse;
  logic [4:0]  o_curCode;
  logic [2:0]  o_curLen;
  logic        o_charValid;
  logic        o_errPulse;
  logic [63:0] o_charBuf;
  logic        o_busy;

  modport master (
    output i_enable, i_keyIn, i_bkspPulse,
    input  o_curCode, o_curLen, o_charValid, o_errPulse, o_charBuf, o_busy
  );

  modport slave (
    input  i_enable, i_keyIn, i_bkspPulse,
    output o_curCode, o_curLen, o_charValid, o_errPulse, o_charBuf, o_busy
  );
endinterface

// File: rtl/morse_input_sequencer.sv
// Decode-mode front end: times Morse key presses into dots/dashes, builds a letter,
// and commits {len,code} into an 8-entry shift buffer at each letter gap.
`timescale 1ns/1ps
module morse_input_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int DOT_MAX    = 3,
  parameter int LETTER_GAP = 7,
  parameter int MAX_SYMS   = 5
) (
  input logic clk,
  input logic rst,
  morse_input_sequencer_if.slave bus
);

  localparam int               DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LP_DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [8:0]       LP_DOT_UNITS = 9'(DOT_MAX);
  localparam logic [7:0]       LP_GAP_LAST  = 8'(LETTER_GAP - 1);
  localparam logic [2:0]       LP_MAX_SYMS  = 3'(MAX_SYMS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_divCnt;
  logic [7:0]       r_unitCnt;
  logic [4:0]       r_curCode;
  logic [2:0]       r_curLen;
  logic             r_charValid;
  logic             r_errPulse;
  logic [63:0]      r_charBuf;
  logic             r_needRelease;

  logic       w_tick;
  logic [8:0] w_pressUnits;
  logic       w_isDash;
  logic       w_gapDone;
  logic       w_letterOpen;

  // The release edge itself may carry the tick that completes the last unit.
  assign w_tick       = (r_divCnt == LP_DIV_LAST);
  assign w_pressUnits = {1'b0, r_unitCnt} + {8'd0, w_tick};
  assign w_isDash     = (w_pressUnits >= LP_DOT_UNITS);
  assign w_gapDone    = w_tick && (r_unitCnt == LP_GAP_LAST);
  assign w_letterOpen = (r_curLen != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_divCnt      <= '0;
      r_unitCnt     <= '0;
      r_curCode     <= '0;
      r_curLen      <= '0;
      r_charValid   <= 1'b0;
      r_errPulse    <= 1'b0;
      r_charBuf     <= '0;
      r_needRelease <= 1'b0;
    end else begin
      r_charValid <= 1'b0;
      r_errPulse  <= 1'b0;

      if (w_tick) begin
        r_divCnt <= '0;
        if (r_unitCnt != 8'hFF) r_unitCnt <= r_unitCnt + 8'd1;
      end else begin
        r_divCnt <= r_divCnt + 1'b1;
      end

      if (!bus.i_enable) begin
        // A key still held when decode mode returns must be released first.
        r_needRelease <= 1'b1;
        r_curCode     <= '0;
        r_curLen      <= '0;
        if (r_state != ST_IDLE) begin
          r_state   <= ST_IDLE;
          r_divCnt  <= '0;
          r_unitCnt <= '0;
        end
      end else begin
        if (!bus.i_keyIn) r_needRelease <= 1'b0;

        case (r_state)
          ST_IDLE: begin
            if (bus.i_bkspPulse && !w_letterOpen)
              r_charBuf <= {8'h00, r_charBuf[63:8]};
            if (bus.i_keyIn && !r_needRelease) begin
              r_state   <= ST_PRESS;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
            end
          end

          ST_PRESS: begin
            if (bus.i_bkspPulse && w_letterOpen) begin
              r_curCode <= '0;
              r_curLen  <= '0;
              r_state   <= ST_IDLE;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
              if (bus.i_keyIn) r_needRelease <= 1'b1;
            end else if (!bus.i_keyIn) begin
              if (r_curLen < LP_MAX_SYMS) begin
                r_curCode[r_curLen] <= w_isDash;
                r_curLen            <= r_curLen + 3'd1;
              end else begin
                r_errPulse <= 1'b1;
              end
              r_state   <= ST_GAP;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
            end
          end

          ST_GAP: begin
            // Commit takes priority over a backspace arriving on the same edge.
            if (w_gapDone) begin
              if (w_letterOpen) begin
                r_charBuf   <= {r_charBuf[55:0], r_curLen, r_curCode};
                r_charValid <= 1'b1;
              end
              r_curCode <= '0;
              r_curLen  <= '0;
              r_state   <= ST_IDLE;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
            end else if (bus.i_bkspPulse && w_letterOpen) begin
              r_curCode <= '0;
              r_curLen  <= '0;
              r_state   <= ST_IDLE;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
            end else if (bus.i_keyIn) begin
              r_state   <= ST_PRESS;
              r_divCnt  <= '0;
              r_unitCnt <= '0;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_divCnt  <= '0;
            r_unitCnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_curCode   = r_curCode;
  assign bus.o_curLen    = r_curLen;
  assign bus.o_charValid = r_charValid;
  assign bus.o_errPulse  = r_errPulse;
  assign bus.o_charBuf   = r_charBuf;
  assign bus.o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_morse_input_sequencer.sv
// Directed bench for morse_input_sequencer: commit/error events are queued by the
// stimulus and checked by an independent monitor; status outputs are checked inline.
`timescale 1ns/1ps
module tb_morse_input_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int DOT_MAX    = 3;
  localparam int LETTER_GAP = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  morse_input_sequencer_if bus();

  morse_input_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .DOT_MAX   (DOT_MAX),
    .LETTER_GAP(LETTER_GAP),
    .MAX_SYMS  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          isErr;
    logic [63:0] charBuf;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monExp;
  int          checkCount = 0;
  int          failCount  = 0;
  logic [63:0] expBuf;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Hold the key at a level for a number of cycles; always entered and left at a negedge.
  task automatic applyStimulus(input logic level, input int cycles);
    bus.i_keyIn = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseBksp();
    bus.i_bkspPulse = 1'b1;
    @(negedge clk);
    bus.i_bkspPulse = 1'b0;
  endtask

  task automatic pushCommit(input int n, input logic [4:0] code);
    logic [2:0] len3;
    len3   = 3'(n);
    expBuf = {expBuf[55:0], len3, code};
    expQ.push_back('{isErr: 1'b0, charBuf: expBuf});
  endtask

  task automatic sendLetter(input int n, input logic [4:0] code);
    pushCommit(n, code);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, code[i] ? 16 : 8);
      if (i < n - 1) applyStimulus(1'b0, 8);
    end
    applyStimulus(1'b0, 40);
  endtask

  // Monitor: every commit or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.o_charValid === 1'b1 || bus.o_errPulse === 1'b1)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", 64'({bus.o_errPulse, bus.o_charValid}), 64'd0);
      end else begin
        monExp = expQ.pop_front();
        if (monExp.isErr) begin
          checkOutput("err_pulse", 64'({bus.o_errPulse, bus.o_charValid}), 64'd2);
        end else begin
          checkOutput("commit_valid", 64'({bus.o_errPulse, bus.o_charValid}), 64'd1);
          checkOutput("commit_buf", bus.o_charBuf, monExp.charBuf);
        end
      end
    end
  end

  initial begin
    bus.i_enable    = 1'b1;
    bus.i_keyIn     = 1'b0;
    bus.i_bkspPulse = 1'b0;
    expBuf          = '0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("reset_cur_code", 64'(bus.o_curCode), 64'd0);
    checkOutput("reset_cur_len", 64'(bus.o_curLen), 64'd0);
    checkOutput("reset_char_valid", 64'(bus.o_charValid), 64'd0);
    checkOutput("reset_err", 64'(bus.o_errPulse), 64'd0);
    checkOutput("reset_char_buf", bus.o_charBuf, 64'd0);
    checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] letter E: single dot");
    pushCommit(1, 5'b00000);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    checkOutput("e_cur_len", 64'(bus.o_curLen), 64'd1);
    checkOutput("e_cur_code", 64'(bus.o_curCode), 64'd0);
    checkOutput("e_busy_gap", 64'(bus.o_busy), 64'd1);
    applyStimulus(1'b0, 36);
    checkOutput("e_buf_low", 64'(bus.o_charBuf[7:0]), 64'h20);
    checkOutput("e_idle_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("e_idle_len", 64'(bus.o_curLen), 64'd0);

    $display("[TB] letter N: dash then dot");
    pushCommit(2, 5'b00001);
    applyStimulus(1'b1, 16);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    checkOutput("n_cur_len", 64'(bus.o_curLen), 64'd2);
    checkOutput("n_cur_code", 64'(bus.o_curCode), 64'h01);
    applyStimulus(1'b0, 36);
    checkOutput("n_buf_low", 64'(bus.o_charBuf[7:0]), 64'h41);
    checkOutput("n_buf_prev", 64'(bus.o_charBuf[15:8]), 64'h20);

    $display("[TB] six dots: overflow");
    expQ.push_back('{isErr: 1'b1, charBuf: 64'd0});
    pushCommit(5, 5'b00000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8);
      if (i < 5) applyStimulus(1'b0, 8);
    end
    applyStimulus(1'b0, 4);
    checkOutput("ovf_cur_len", 64'(bus.o_curLen), 64'd5);
    checkOutput("ovf_cur_code", 64'(bus.o_curCode), 64'd0);
    applyStimulus(1'b0, 36);
    checkOutput("ovf_buf", bus.o_charBuf, 64'h2041A0);

    $display("[TB] backspace drains buffer");
    pulseBksp();
    checkOutput("bksp1_buf", bus.o_charBuf, 64'h2041);
    pulseBksp();
    checkOutput("bksp2_buf", bus.o_charBuf, 64'h20);
    pulseBksp();
    checkOutput("bksp3_buf", bus.o_charBuf, 64'h0);
    pulseBksp();
    checkOutput("bksp_empty_buf", bus.o_charBuf, 64'h0);
    expBuf = '0;

    $display("[TB] E, T, then backspaces");
    sendLetter(1, 5'b00000);
    sendLetter(1, 5'b00001);
    checkOutput("et_buf", bus.o_charBuf, 64'h2021);
    pulseBksp();
    checkOutput("et_bksp1", bus.o_charBuf, 64'h20);
    pulseBksp();
    checkOutput("et_bksp2", bus.o_charBuf, 64'h0);
    expBuf = '0;

    $display("[TB] backspace mid-letter in gap");
    applyStimulus(1'b1, 16);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    checkOutput("mid_len_before", 64'(bus.o_curLen), 64'd2);
    pulseBksp();
    checkOutput("mid_len_after", 64'(bus.o_curLen), 64'd0);
    checkOutput("mid_busy", 64'(bus.o_busy), 64'd0);
    applyStimulus(1'b0, 40);
    checkOutput("mid_buf", bus.o_charBuf, 64'h0);

    $display("[TB] backspace while key held");
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 8);
    pulseBksp();
    checkOutput("hold_len", 64'(bus.o_curLen), 64'd0);
    applyStimulus(1'b1, 20);
    checkOutput("hold_busy", 64'(bus.o_busy), 64'd0);
    applyStimulus(1'b0, 40);
    checkOutput("hold_buf", bus.o_charBuf, 64'h0);

    $display("[TB] nine letters overflow the buffer");
    sendLetter(1, 5'b00001);
    sendLetter(2, 5'b00001);
    for (int i = 0; i < 7; i++) sendLetter(1, 5'b00000);
    checkOutput("nine_buf", bus.o_charBuf, 64'h4120202020202020);
    checkOutput("nine_top", 64'(bus.o_charBuf[63:56]), 64'h41);

    $display("[TB] disable during press");
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 8);
    checkOutput("en_busy_pre", 64'(bus.o_busy), 64'd1);
    bus.i_enable = 1'b0;
    pulseBksp();
    checkOutput("en_len", 64'(bus.o_curLen), 64'd0);
    checkOutput("en_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("en_buf", bus.o_charBuf, 64'h4120202020202020);
    bus.i_enable = 1'b1;
    applyStimulus(1'b1, 12);
    checkOutput("en_hold_busy", 64'(bus.o_busy), 64'd0);
    applyStimulus(1'b0, 40);
    checkOutput("en_buf_after", bus.o_charBuf, 64'h4120202020202020);

    $display("[TB] reset during gap");
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 4);
    checkOutput("rg_len_before", 64'(bus.o_curLen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rg_len", 64'(bus.o_curLen), 64'd0);
    checkOutput("rg_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("rg_buf", bus.o_charBuf, 64'h0);
    rst    = 1'b0;
    expBuf = '0;
    applyStimulus(1'b0, 40);
    checkOutput("rg_buf_after", bus.o_charBuf, 64'h0);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
